// File: rtl/dac_wave_pkg.sv
// rtl/dac_wave_pkg.sv - shared codes, FSM encodings and helpers for dac_wave_ctrl
// Purpose: mode codes, waveform FSM state encodings, DAC constants and the mode
//          rotation helpers used by the DAC waveform sequencer.
// Ports:   none (package).
package dac_wave_pkg;

    localparam logic [1:0] MODE_SAW = 2'd0;
    localparam logic [1:0] MODE_TRI = 2'd1;
    localparam logic [1:0] MODE_SQ  = 2'd2;

    localparam logic [3:0] DAC_MAX = 4'hF;
    localparam logic [3:0] SQ_HALF = 4'hF;

    typedef enum logic [2:0] {
        ST_SAW    = 3'd0,
        ST_TRI_UP = 3'd1,
        ST_TRI_DN = 3'd2,
        ST_SQ_LO  = 3'd3,
        ST_SQ_HI  = 3'd4
    } wave_state_e;

    // SAW -> TRI -> SQ -> SAW; any stray code falls back to SAW.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        case (mode)
            MODE_SAW: next_mode = MODE_TRI;
            MODE_TRI: next_mode = MODE_SQ;
            default:  next_mode = MODE_SAW;
        endcase
    endfunction

    // First FSM state of a period for the given mode.
    function automatic wave_state_e mode_entry(input logic [1:0] mode);
        case (mode)
            MODE_TRI: mode_entry = ST_TRI_UP;
            MODE_SQ:  mode_entry = ST_SQ_LO;
            default:  mode_entry = ST_SAW;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - stable-level debouncer with press pulse for an active-low key
// Purpose: accepts a new key level only after it has differed from the current
//          stable level for DEB_CYCLES consecutive clocks; a 1->0 acceptance
//          produces a single-cycle press pulse.
// Ports:   clk_i    system clock
//          rst_ni   async active-low reset (stable level resets to released = 1)
//          key_i    already-synchronized key level, low = pressed
//          level_o  debounced stable level
//          press_o  1-cycle pulse on an accepted press
module key_debounce #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 19
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (key_i == level_q) begin
            // Any return to the stable level restarts the qualification window.
            cnt_d = '0;
        end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            level_d = key_i;
            cnt_d   = '0;
            press_d = ~key_i;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/dac_wave_ctrl.sv
// rtl/dac_wave_ctrl.sv - sawtooth/triangle/square sequencer for the 4-bit R-2R DAC
// Purpose: prescaler + rate counter generate the step tick; a waveform FSM
//          produces the DAC code; KEY[0] presses request a mode change that is
//          applied, together with the SW rate, only at a period boundary.
//          Optional macro DAC_WAVE_AMPL_EN: VGA_R = val >> SW[3:2] (shift
//          latched at the boundary).
// Ports:   MAX10_CLK1_50  system clock
//          KEY[1]         async active-low reset; KEY[0] mode button, low = pressed
//          SW[1:0]        rate select; SW[3:2] amplitude shift (macro only)
//          VGA_R          registered DAC code
//          LEDR[1:0]      current mode; LEDR[2] mode change pending
module dac_wave_ctrl #(
    parameter int BASE_DIV   = 1024,
    parameter int DIV_W      = 10,
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 19
) (
    input  logic       MAX10_CLK1_50,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [3:0] VGA_R,
    output logic [2:0] LEDR
);

    import dac_wave_pkg::*;

    logic clk;
    logic rst_n;
    assign clk   = MAX10_CLK1_50;
    assign rst_n = KEY[1];

    logic [1:0]       sync_q;
    logic             key_level;
    logic             press;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       rcnt_q, rcnt_d;
    logic [1:0]       rate_q, rate_d;
    logic [1:0]       mode_q, mode_d;
    logic             pending_q, pending_d;
    wave_state_e      state_q, state_d;
    logic [3:0]       val_q, val_d;
    logic [3:0]       phase_q, phase_d;
    logic             step;
    logic             boundary;
    logic             div_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], KEY[0]};
    end

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_key_debounce (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .key_i  (sync_q[1]),
        .level_o(key_level),
        .press_o(press)
    );

    assign div_max = (div_q == DIV_W'(BASE_DIV - 1));
    assign step    = div_max && (rcnt_q == rate_q);

    always_comb begin
        div_d     = div_q;
        rcnt_d    = rcnt_q;
        rate_d    = rate_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        state_d   = state_q;
        val_d     = val_q;
        phase_d   = phase_q;
        boundary  = 1'b0;

        if (div_max) begin
            div_d  = '0;
            rcnt_d = (rcnt_q == rate_q) ? 2'd0 : rcnt_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (step) begin
            case (state_q)
                ST_SAW: begin
                    val_d    = val_q + 4'd1;
                    boundary = (val_q == DAC_MAX);
                end
                ST_TRI_UP: begin
                    val_d = val_q + 4'd1;
                    if (val_q == DAC_MAX - 4'd1) state_d = ST_TRI_DN;
                end
                ST_TRI_DN: begin
                    val_d = val_q - 4'd1;
                    if (val_q == 4'd1) begin
                        boundary = 1'b1;
                        state_d  = ST_TRI_UP;
                    end
                end
                ST_SQ_LO: begin
                    val_d   = 4'd0;
                    phase_d = phase_q + 4'd1;
                    if (phase_q == 4'hF) begin
                        state_d = ST_SQ_HI;
                        val_d   = SQ_HALF;
                        phase_d = 4'd0;
                    end
                end
                ST_SQ_HI: begin
                    val_d   = SQ_HALF;
                    phase_d = phase_q + 4'd1;
                    if (phase_q == 4'hF) begin
                        boundary = 1'b1;
                        state_d  = ST_SQ_LO;
                        val_d    = 4'd0;
                        phase_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SAW;
                    val_d   = 4'd0;
                    phase_d = 4'd0;
                end
            endcase
        end

        // A press pulse landing on the boundary cycle counts as pending.
        if (boundary) begin
            rate_d = SW[1:0];
            if (pending_q || press) begin
                mode_d    = next_mode(mode_q);
                state_d   = mode_entry(mode_d);
                val_d     = 4'd0;
                phase_d   = 4'd0;
                pending_d = 1'b0;
            end
        end else if (press) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            rcnt_q    <= 2'd0;
            rate_q    <= 2'd0;
            mode_q    <= MODE_SAW;
            pending_q <= 1'b0;
            state_q   <= ST_SAW;
            val_q     <= 4'd0;
            phase_q   <= 4'd0;
        end else begin
            div_q     <= div_d;
            rcnt_q    <= rcnt_d;
            rate_q    <= rate_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            val_q     <= val_d;
            phase_q   <= phase_d;
        end
    end

    logic unused_key_level;
    assign unused_key_level = key_level;

`ifdef DAC_WAVE_AMPL_EN
    logic [1:0] shift_q, shift_d;
    logic [3:0] vga_q;

    // The shift only changes at a boundary, where val_d is 0, so the output
    // never shows a mixed old/new scale.
    assign shift_d = boundary ? SW[3:2] : shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 2'd0;
            vga_q   <= 4'd0;
        end else begin
            shift_q <= shift_d;
            vga_q   <= val_d >> shift_d;
        end
    end

    assign VGA_R = vga_q;
`else
    logic unused_sw;
    assign unused_sw = ^SW[3:2];
    assign VGA_R     = val_q;
`endif

    assign LEDR = {pending_q, mode_q};

endmodule
